// File: rtl/nonce_sweep_ctrl.sv
// nonce_sweep_ctrl: walks the hash core through an inclusive nonce range.
// Each nonce is issued with a one-cycle core_start. The digest returned with
// core_done is registered, then compared against a leading-zero target. The
// sweep stops on the first match, when the range is used up, or on abort.
module nonce_sweep_ctrl #(
  parameter int NONCE_W  = 32,
  parameter int DIGEST_W = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [NONCE_W-1:0]  nonce_start,
  input  logic [NONCE_W-1:0]  nonce_end,
  input  logic [7:0]          zero_bits,
  output logic                core_start,
  output logic [NONCE_W-1:0]  core_nonce,
  input  logic                core_done,
  input  logic [DIGEST_W-1:0] core_digest,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic                exhausted,
  output logic [NONCE_W-1:0]  found_nonce,
  output logic [NONCE_W-1:0]  attempts
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CHECK,
    S_DRAIN
  } state_t;

  state_t               state, state_nx;
  logic [NONCE_W-1:0]   cur, cur_nx;
  logic [NONCE_W-1:0]   last, last_nx;
  logic [7:0]           zbits, zbits_nx;
  logic                 done_nx, found_nx, exhausted_nx;
  logic [NONCE_W-1:0]   found_nonce_nx, attempts_nx;
  logic [DIGEST_W-1:0]  digest_q;
  logic                 match;

  // True when the top n bits of d are all zero; n = 0 always matches.
  function automatic logic lead_zero_ok(input logic [DIGEST_W-1:0] d,
                                        input logic [7:0]          n);
    logic ok;
    int   n_int;
    ok    = 1'b1;
    n_int = int'(n);
    for (int i = 0; i < DIGEST_W; i++) begin
      if ((i < n_int) && d[DIGEST_W-1-i]) ok = 1'b0;
    end
    return ok;
  endfunction

  // Attempt counter sticks at all-ones instead of wrapping.
  function automatic logic [NONCE_W-1:0] sat_inc(input logic [NONCE_W-1:0] a);
    return (&a) ? a : a + 1'b1;
  endfunction

  assign match      = lead_zero_ok(digest_q, zbits);
  assign core_start = (state == S_ISSUE);
  assign core_nonce = cur;
  assign busy       = (state != S_IDLE);

  // Digest register: decouples the compare from the core's output bus.
  always_ff @(posedge clk) begin
    if ((state == S_WAIT) && core_done) digest_q <= core_digest;
  end

  // Next-state and next-result logic for the sweep sequencer.
  always_comb begin
    state_nx       = state;
    cur_nx         = cur;
    last_nx        = last;
    zbits_nx       = zbits;
    done_nx        = 1'b0;
    found_nx       = found;
    exhausted_nx   = exhausted;
    found_nonce_nx = found_nonce;
    attempts_nx    = attempts;
    case (state)
      S_IDLE: begin
        // abort in the same cycle as start cancels the request
        if (start && !abort) begin
          cur_nx         = nonce_start;
          last_nx        = nonce_end;
          zbits_nx       = zero_bits;
          found_nx       = 1'b0;
          exhausted_nx   = 1'b0;
          found_nonce_nx = '0;
          attempts_nx    = '0;
          state_nx       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nx = abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (abort) begin
          // a core_done arriving with the abort already closes the job
          state_nx = core_done ? S_IDLE : S_DRAIN;
        end else if (core_done) begin
          attempts_nx = sat_inc(attempts);
          state_nx    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_nx = S_IDLE;
        end else if (match) begin
          found_nx       = 1'b1;
          found_nonce_nx = cur;
          done_nx        = 1'b1;
          state_nx       = S_IDLE;
        end else if (cur == last) begin
          exhausted_nx = 1'b1;
          done_nx      = 1'b1;
          state_nx     = S_IDLE;
        end else begin
          cur_nx   = cur + 1'b1;
          state_nx = S_ISSUE;
        end
      end
      S_DRAIN: begin
        // the core is still busy with an abandoned nonce; wait it out
        if (core_done) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State and result registers; reset returns everything to idle/zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cur         <= '0;
      last        <= '0;
      zbits       <= '0;
      done        <= 1'b0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      found_nonce <= '0;
      attempts    <= '0;
    end else begin
      state       <= state_nx;
      cur         <= cur_nx;
      last        <= last_nx;
      zbits       <= zbits_nx;
      done        <= done_nx;
      found       <= found_nx;
      exhausted   <= exhausted_nx;
      found_nonce <= found_nonce_nx;
      attempts    <= attempts_nx;
    end
  end

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Bench for nonce_sweep_ctrl: fixed-latency hash core model plus directed
// sweeps with hand-computed expected nonces, timings and result flags.
module tb_nonce_sweep_ctrl;

  localparam int NW = 32;
  localparam int DW = 256;
  localparam int L  = 65;

  logic          clk = 1'b0;
  logic          reset;
  logic          start, abort;
  logic [NW-1:0] nonce_start, nonce_end;
  logic [7:0]    zero_bits;
  logic          core_start;
  logic [NW-1:0] core_nonce;
  logic          core_done;
  logic [DW-1:0] core_digest;
  logic          busy, done, found, exhausted;
  logic [NW-1:0] found_nonce, attempts;

  int checks   = 0;
  int failures = 0;

  nonce_sweep_ctrl #(.NONCE_W(NW), .DIGEST_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .zero_bits(zero_bits),
    .core_start(core_start), .core_nonce(core_nonce),
    .core_done(core_done), .core_digest(core_digest),
    .busy(busy), .done(done), .found(found), .exhausted(exhausted),
    .found_nonce(found_nonce), .attempts(attempts)
  );

  always #5 clk = ~clk;

  // Hash core model: all-ones digest except 20 leading zeros at nonce 0x102.
  function automatic logic [DW-1:0] digest_for(input logic [NW-1:0] n);
    logic [DW-1:0] d;
    d = '1;
    if (n == 32'h0000_0102) d = d >> 20;
    return d;
  endfunction

  int            mcnt;
  logic [NW-1:0] mnonce;

  // core_done goes high L cycles after the cycle in which core_start was high
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mcnt        <= 0;
      mnonce      <= '0;
      core_done   <= 1'b0;
      core_digest <= '1;
    end else begin
      core_done <= 1'b0;
      if (core_start) begin
        mcnt   <= L - 1;
        mnonce <= core_nonce;
      end else if (mcnt == 1) begin
        mcnt        <= 0;
        core_done   <= 1'b1;
        core_digest <= digest_for(mnonce);
      end else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
      end
    end
  end

  // Event log: time stamp = number of the rising edge ending the cycle.
  int            pcount = 0;
  int            cs_t[$];
  logic [NW-1:0] cs_nonce[$];
  int            done_t[$];

  always @(posedge clk) begin
    pcount <= pcount + 1;
    if (core_start) begin
      cs_t.push_back(pcount + 1);
      cs_nonce.push_back(core_nonce);
    end
    if (done) done_t.push_back(pcount + 1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse start for one edge; s_edge is the number of that accepting edge.
  task automatic run_sweep(input logic [NW-1:0] s, input logic [NW-1:0] e,
                           input logic [7:0] zb, output int s_edge);
    @(negedge clk);
    nonce_start = s;
    nonce_end   = e;
    zero_bits   = zb;
    start       = 1'b1;
    s_edge      = pcount + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
    if (!ok) chk({tag, "_timeout"}, 64'd0, 64'd1);
    @(negedge clk);
  endtask

  initial begin
    int se, cb, db;
    bit ok;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    nonce_start = '0; nonce_end = '0; zero_bits = '0;
    #1;
    chk("rst_outs", 64'({core_start, busy, done, found, exhausted}), 64'd0);
    chk("rst_nonces", 64'({core_nonce, found_nonce}), 64'd0);
    chk("rst_attempts", 64'(attempts), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // zero_bits = 0: first nonce always matches
    cb = cs_t.size(); db = done_t.size();
    run_sweep(32'd5, 32'd9, 8'd0, se);
    chk("t1_busy_c1", 64'(busy), 64'd1);
    wait_idle("t1", 300);
    chk("t1_ncs", 64'(cs_t.size() - cb), 64'd1);
    chk("t1_nonce", 64'(cs_nonce[cb]), 64'd5);
    chk("t1_cs_lat", 64'(cs_t[cb] - se), 64'd1);
    chk("t1_done_lat", 64'(done_t[db] - se), 64'd68);
    chk("t1_flags", 64'({found, exhausted}), 64'b10);
    chk("t1_fnonce", 64'(found_nonce), 64'd5);
    chk("t1_attempts", 64'(attempts), 64'd1);

    // 20 leading zeros at 0x102 meet a 20-bit target on the third nonce
    cb = cs_t.size(); db = done_t.size();
    run_sweep(32'h100, 32'h1FF, 8'd20, se);
    wait_idle("t2", 1000);
    chk("t2_ncs", 64'(cs_t.size() - cb), 64'd3);
    chk("t2_n0", 64'(cs_nonce[cb]), 64'h100);
    chk("t2_n1", 64'(cs_nonce[cb+1]), 64'h101);
    chk("t2_n2", 64'(cs_nonce[cb+2]), 64'h102);
    chk("t2_gap01", 64'(cs_t[cb+1] - cs_t[cb]), 64'd67);
    chk("t2_gap12", 64'(cs_t[cb+2] - cs_t[cb+1]), 64'd67);
    chk("t2_flags", 64'({found, exhausted}), 64'b10);
    chk("t2_fnonce", 64'(found_nonce), 64'h102);
    chk("t2_attempts", 64'(attempts), 64'd3);
    chk("t2_ndone", 64'(done_t.size() - db), 64'd1);

    // 21-bit target is one bit too strict: range runs out
    cb = cs_t.size(); db = done_t.size();
    run_sweep(32'h100, 32'h103, 8'd21, se);
    wait_idle("t3", 1000);
    chk("t3_ncs", 64'(cs_t.size() - cb), 64'd4);
    chk("t3_flags", 64'({found, exhausted}), 64'b01);
    chk("t3_fnonce", 64'(found_nonce), 64'd0);
    chk("t3_attempts", 64'(attempts), 64'd4);
    chk("t3_ndone", 64'(done_t.size() - db), 64'd1);
    chk("t3_done_lat", 64'(done_t[db] - se), 64'(1 + 3*67 + 67));

    // range wraps through zero
    cb = cs_t.size(); db = done_t.size();
    run_sweep(32'hFFFF_FFFE, 32'h0000_0001, 8'd255, se);
    wait_idle("t4", 1000);
    chk("t4_ncs", 64'(cs_t.size() - cb), 64'd4);
    chk("t4_n0", 64'(cs_nonce[cb]), 64'hFFFF_FFFE);
    chk("t4_n1", 64'(cs_nonce[cb+1]), 64'hFFFF_FFFF);
    chk("t4_n2", 64'(cs_nonce[cb+2]), 64'h0000_0000);
    chk("t4_n3", 64'(cs_nonce[cb+3]), 64'h0000_0001);
    chk("t4_flags", 64'({found, exhausted}), 64'b01);
    chk("t4_attempts", 64'(attempts), 64'd4);

    // abort 10 cycles into the second nonce's wait, start pulse while draining
    cb = cs_t.size(); db = done_t.size();
    run_sweep(32'd0, 32'd100, 8'd255, se);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (cs_t.size() >= cb + 2) ok = 1'b1;
    end
    if (!ok) chk("t5_cs2_timeout", 64'd0, 64'd1);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_drain_busy", 64'(busy), 64'd1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (core_done) ok = 1'b1;
    end
    if (!ok) chk("t5_cdone_timeout", 64'd0, 64'd1);
    chk("t5_busy_at_cdone", 64'(busy), 64'd1);
    @(negedge clk);
    chk("t5_busy_after", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);
    chk("t5_ncs", 64'(cs_t.size() - cb), 64'd2);
    chk("t5_ndone", 64'(done_t.size() - db), 64'd0);
    chk("t5_flags", 64'({found, exhausted}), 64'b00);
    chk("t5_attempts", 64'(attempts), 64'd1);

    // reset in the middle of a wait clears everything at once
    cb = cs_t.size();
    run_sweep(32'd7, 32'd10, 8'd255, se);
    repeat (10) @(negedge clk);
    chk("t6_pre_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("t6_rst_outs", 64'({core_start, busy, done, found, exhausted}), 64'd0);
    chk("t6_rst_nonces", 64'({core_nonce, found_nonce}), 64'd0);
    chk("t6_rst_attempts", 64'(attempts), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    cb = cs_t.size();
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("t6_sa_busy", 64'(busy), 64'd0);
    repeat (5) @(negedge clk);
    chk("t6_sa_busy_later", 64'(busy), 64'd0);
    chk("t6_sa_ncs", 64'(cs_t.size() - cb), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
